// File: rtl/multi_alarm_pkg.sv
// Shared types and constants for the multi-channel alarm controller.
// Channel state encoding, datapath widths and the minutes-to-load helper.
package multi_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2,
    ST_LOCKOUT = 2'd3
  } chan_state_t;

  localparam int TIME_W    = 16;
  localparam int CNT_W     = 10;
  localparam int SNZ_CNT_W = 4;

  // Counter reload value: the counter expires on the edge where it reads zero,
  // so loading minutes*60-1 gives exactly minutes*60 edges in the state.
  function automatic logic [CNT_W-1:0] minutes_to_load(input int unsigned minutes);
    int unsigned secs;
    secs = minutes * 60 - 1;
    return secs[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_channel.sv
// One alarm channel: match detection, ring/snooze/lockout FSM, episode counter
// and snooze count. Snooze/dismiss arrive as single-edge pulses from the top.
module alarm_channel
  import multi_alarm_pkg::*;
#(
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 9,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic              clk_1hz,
  input  logic              reset,
  input  logic              en,
  input  logic              arm,
  input  logic              clock_pm,
  input  logic [TIME_W-1:0] clock_hhmm,
  input  logic              alarm_pm,
  input  logic [TIME_W-1:0] alarm_hhmm,
  input  logic              snooze_edge,
  input  logic              dismiss_edge,
  output logic              ringing,
  output logic              snoozed,
  output chan_state_t       state
);

  localparam logic [CNT_W-1:0]     RING_LOAD   = minutes_to_load(RING_MINUTES);
  localparam logic [CNT_W-1:0]     SNOOZE_LOAD = minutes_to_load(SNOOZE_MINUTES);
  localparam logic [SNZ_CNT_W-1:0] SNZ_LIMIT   = SNZ_CNT_W'(MAX_SNOOZES);

  chan_state_t          state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [SNZ_CNT_W-1:0] snz_cnt, snz_cnt_next;
  logic                 match, match_q;

  assign match = en & arm & (clock_pm == alarm_pm) & (clock_hhmm == alarm_hhmm);

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      snz_cnt <= '0;
      match_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      snz_cnt <= snz_cnt_next;
      match_q <= match;
    end
  end

  // Priority: disable > dismiss > snooze > counter expiry > trigger.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    snz_cnt_next = snz_cnt;
    if (!en || !arm) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match && !match_q) begin
            state_next   = ST_RINGING;
            cnt_next     = RING_LOAD;
            snz_cnt_next = '0;
          end
        end
        ST_RINGING: begin
          if (dismiss_edge) begin
            state_next = ST_LOCKOUT;
          end else if (snooze_edge && (snz_cnt < SNZ_LIMIT)) begin
            state_next   = ST_SNOOZED;
            cnt_next     = SNOOZE_LOAD;
            snz_cnt_next = snz_cnt + SNZ_CNT_W'(1);
          end else if (cnt == '0) begin
            state_next = ST_LOCKOUT;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_SNOOZED: begin
          if (dismiss_edge) begin
            state_next = ST_LOCKOUT;
          end else if (cnt == '0) begin
            state_next = ST_RINGING;
            cnt_next   = RING_LOAD;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (!match) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ringing = (state == ST_RINGING);
  assign snoozed = (state == ST_SNOOZED);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller top: snooze/dismiss edge detection, channel
// array, blink phase and display/buzzer gating. Outputs depend on registers only.
module multi_alarm_ctrl
  import multi_alarm_pkg::*;
#(
  parameter int NUM_ALARMS     = 2,
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 9,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic                         clk_1hz,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clock_pm,
  input  logic [TIME_W-1:0]            clock_hhmm,
  input  logic [NUM_ALARMS-1:0]        alarm_pm,
  input  logic [TIME_W*NUM_ALARMS-1:0] alarm_hhmm,
  input  logic [NUM_ALARMS-1:0]        alarm_arm,
  input  logic                         snooze,
  input  logic                         dismiss,
  output logic [NUM_ALARMS-1:0]        ringing,
  output logic [NUM_ALARMS-1:0]        snoozed,
  output logic                         display_on,
  output logic                         beep_en,
  output logic [2*NUM_ALARMS-1:0]      chan_state
);

  logic snooze_q, dismiss_q, blink_phase;
  logic snooze_edge, dismiss_edge, any_ringing;

  assign snooze_edge  = snooze & ~snooze_q;
  assign dismiss_edge = dismiss & ~dismiss_q;
  assign any_ringing  = |ringing;

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      snooze_q    <= 1'b0;
      dismiss_q   <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      snooze_q    <= snooze;
      dismiss_q   <= dismiss;
      blink_phase <= any_ringing ? ~blink_phase : 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
    chan_state_t st;

    alarm_channel #(
      .RING_MINUTES  (RING_MINUTES),
      .SNOOZE_MINUTES(SNOOZE_MINUTES),
      .MAX_SNOOZES   (MAX_SNOOZES)
    ) u_chan (
      .clk_1hz     (clk_1hz),
      .reset       (reset),
      .en          (en),
      .arm         (alarm_arm[i]),
      .clock_pm    (clock_pm),
      .clock_hhmm  (clock_hhmm),
      .alarm_pm    (alarm_pm[i]),
      .alarm_hhmm  (alarm_hhmm[TIME_W*i +: TIME_W]),
      .snooze_edge (snooze_edge),
      .dismiss_edge(dismiss_edge),
      .ringing     (ringing[i]),
      .snoozed     (snoozed[i]),
      .state       (st)
    );

    assign chan_state[2*i +: 2] = st;
  end

  // Ringing alternates beep-on/display-lit with beep-off/display-blank.
  assign display_on = ~(any_ringing & blink_phase);
  assign beep_en    = any_ringing & ~blink_phase;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a seconds-remaining behavioural model and literal pins.
module tb_multi_alarm_ctrl;
  import multi_alarm_pkg::*;

  localparam int NA      = 2;
  localparam int RING_M  = 5;
  localparam int SNZ_M   = 9;
  localparam int MAX_SNZ = 3;
  localparam int W       = 2 * NA + 2;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_LOCK = 3;

  logic              clk_1hz = 1'b0;
  logic              reset, en, clock_pm, snooze, dismiss;
  logic [15:0]       clock_hhmm;
  logic [NA-1:0]     alarm_pm, alarm_arm, ringing, snoozed;
  logic [16*NA-1:0]  alarm_hhmm;
  logic              display_on, beep_en;
  logic [2*NA-1:0]   chan_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  multi_alarm_ctrl #(
    .NUM_ALARMS(NA), .RING_MINUTES(RING_M), .SNOOZE_MINUTES(SNZ_M), .MAX_SNOOZES(MAX_SNZ)
  ) dut (
    .clk_1hz(clk_1hz), .reset(reset), .en(en), .clock_pm(clock_pm),
    .clock_hhmm(clock_hhmm), .alarm_pm(alarm_pm), .alarm_hhmm(alarm_hhmm),
    .alarm_arm(alarm_arm), .snooze(snooze), .dismiss(dismiss),
    .ringing(ringing), .snoozed(snoozed), .display_on(display_on),
    .beep_en(beep_en), .chan_state(chan_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: mode per channel and seconds left in the current episode
  int m_mode[NA];
  int m_left[NA];
  int m_nsnz[NA];
  bit m_prev_match[NA];
  bit m_prev_snz, m_prev_dis, m_blink;

  function automatic logic [W-1:0] model_outputs();
    logic [NA-1:0] r, s;
    bit any;
    for (int i = 0; i < NA; i++) begin
      r[i] = (m_mode[i] == M_RING);
      s[i] = (m_mode[i] == M_SNZ);
    end
    any = |r;
    return {r, s, !(any && m_blink), any && !m_blink};
  endfunction

  always @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NA; i++) begin
        m_mode[i] = M_IDLE; m_left[i] = 0; m_nsnz[i] = 0; m_prev_match[i] = 0;
      end
      m_prev_snz = 0; m_prev_dis = 0; m_blink = 0;
      exp_q.delete();
    end else begin
      bit any_ring, snz_e, dis_e, match;
      any_ring = 0;
      for (int i = 0; i < NA; i++) if (m_mode[i] == M_RING) any_ring = 1;
      snz_e = snooze && !m_prev_snz;
      dis_e = dismiss && !m_prev_dis;
      for (int i = 0; i < NA; i++) begin
        match = en && alarm_arm[i] && (clock_pm == alarm_pm[i]) &&
                (clock_hhmm == alarm_hhmm[16*i +: 16]);
        if (!en || !alarm_arm[i]) m_mode[i] = M_IDLE;
        else if (m_mode[i] == M_IDLE) begin
          if (match && !m_prev_match[i]) begin
            m_mode[i] = M_RING; m_left[i] = RING_M * 60; m_nsnz[i] = 0;
          end
        end else if (m_mode[i] == M_RING) begin
          if (dis_e) m_mode[i] = M_LOCK;
          else if (snz_e && m_nsnz[i] < MAX_SNZ) begin
            m_mode[i] = M_SNZ; m_left[i] = SNZ_M * 60; m_nsnz[i]++;
          end else begin
            m_left[i]--;
            if (m_left[i] == 0) m_mode[i] = M_LOCK;
          end
        end else if (m_mode[i] == M_SNZ) begin
          if (dis_e) m_mode[i] = M_LOCK;
          else begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_mode[i] = M_RING; m_left[i] = RING_M * 60; end
          end
        end else if (!match) m_mode[i] = M_IDLE;
        m_prev_match[i] = match;
      end
      m_blink = any_ring ? !m_blink : 0;
      m_prev_snz = snooze;
      m_prev_dis = dismiss;
      exp_q.push_back(model_outputs());
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk_1hz) begin
    if (!reset && exp_q.size() > 0)
      check("outputs", {ringing, snoozed, display_on, beep_en}, exp_q.pop_front());
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_1hz);
  endtask

  task automatic set_alarm(input int ch, input logic [15:0] hhmm, input logic pm);
    alarm_hhmm[16*ch +: 16] = hhmm;
    alarm_pm[ch] = pm;
  endtask

  task automatic set_clock(input logic [15:0] hhmm, input logic pm);
    clock_hhmm = hhmm;
    clock_pm = pm;
  endtask

  task automatic count_while(input int ch, input bit use_snz, input int limit, output int n);
    n = 0;
    while (n < limit && (use_snz ? snoozed[ch] : ringing[ch])) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; tick(); snooze = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; en = 1'b1; snooze = 1'b0; dismiss = 1'b0;
    alarm_arm = '0; alarm_pm = '0; alarm_hhmm = '0;
    set_clock(16'h0000, 1'b0);
    tick(2);
    check("reset_ringing", ringing, 0);
    check("reset_snoozed", snoozed, 0);
    check("reset_display", display_on, 1);
    check("reset_beep", beep_en, 0);
    reset = 1'b0;

    // single alarm rings for full duration, no retrigger within the minute
    set_alarm(0, 16'h0730, 1'b0); alarm_arm = 2'b01;
    set_clock(16'h0729, 1'b0); tick(3);
    set_clock(16'h0730, 1'b0); tick();
    check("trig_ring0", ringing[0], 1);
    check("trig_beep", beep_en, 1);
    count_while(0, 0, 1000, n);
    check("ring_len", n, RING_M * 60);
    seen = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (ringing[0]) seen = 1; end
    check("no_retrigger", seen, 0);
    set_clock(16'h0731, 1'b0); tick(2);

    // snooze at edge 10, resume after full snooze with full ring
    set_alarm(0, 16'h0800, 1'b0);
    set_clock(16'h0759, 1'b0); tick(2);
    set_clock(16'h0800, 1'b0); tick();
    tick(9);
    pulse_snooze();
    check("snz_state", {ringing[0], snoozed[0]}, 2'b01);
    count_while(0, 1, 1000, n);
    check("snz_len", n, SNZ_M * 60);
    check("resume_ring", ringing[0], 1);
    count_while(0, 0, 1000, n);
    check("resume_len", n, RING_M * 60);
    set_clock(16'h0801, 1'b0); tick(2);

    // fourth snooze ignored, channel times out to lockout
    set_alarm(0, 16'h0900, 1'b0);
    set_clock(16'h0859, 1'b0); tick(2);
    set_clock(16'h0900, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      tick(3);
      pulse_snooze();
      if (k < 3) begin
        check("snz_taken", snoozed[0], 1);
        count_while(0, 1, 1000, n);
      end
    end
    check("snz4_ignored", {ringing[0], snoozed[0]}, 2'b10);
    count_while(0, 0, 1000, n);
    check("snz4_remaining", n, RING_M * 60 - 4);
    check("lockout_state", chan_state[1:0], ST_LOCKOUT);
    set_clock(16'h0901, 1'b0); tick(2);

    // two channels, dismiss, then PM mismatch
    set_alarm(0, 16'h0600, 1'b1); set_alarm(1, 16'h0600, 1'b1); alarm_arm = 2'b11;
    set_clock(16'h0559, 1'b1); tick(2);
    set_clock(16'h0600, 1'b1); tick();
    check("both_ring", ringing, 2'b11);
    tick();
    check("blink_blank", {display_on, beep_en}, 2'b00);
    tick(2);
    dismiss = 1'b1; tick(); dismiss = 1'b0;
    check("dismiss_all", {ringing, display_on, beep_en}, {2'b00, 2'b10});
    alarm_pm = 2'b00;
    set_clock(16'h0559, 1'b1); tick(2);
    set_clock(16'h0600, 1'b1); tick(5);
    check("pm_mismatch", ringing, 0);

    // disarm while snoozed; global enable low while ringing
    set_alarm(1, 16'h1000, 1'b0); alarm_arm = 2'b10;
    set_clock(16'h0959, 1'b0); tick(2);
    set_clock(16'h1000, 1'b0); tick();
    check("ch1_ring", ringing[1], 1);
    pulse_snooze();
    check("ch1_snz", snoozed[1], 1);
    alarm_arm = 2'b00; tick();
    check("disarm_snz", snoozed[1], 0);
    seen = 0;
    for (int i = 0; i < 600; i++) begin tick(); if (ringing != 0) seen = 1; end
    check("disarm_quiet", seen, 0);
    set_alarm(0, 16'h1100, 1'b0); alarm_arm = 2'b01;
    set_clock(16'h1059, 1'b0); tick(2);
    set_clock(16'h1100, 1'b0); tick(3);
    en = 1'b0; tick();
    check("en_low", {ringing, snoozed, display_on, beep_en}, 6'b000010);
    set_clock(16'h1101, 1'b0); tick(); en = 1'b1; tick();

    // asynchronous reset mid-ring, fresh trigger after release
    set_alarm(0, 16'h1200, 1'b1);
    set_clock(16'h1159, 1'b0); tick(2);
    set_clock(16'h1200, 1'b1); tick();
    check("noon_ring", ringing[0], 1);
    tick(4);
    #2 reset = 1'b1;
    #1 check("async_reset", {ringing, snoozed, display_on, beep_en}, 6'b000010);
    tick(); reset = 1'b0;
    tick();
    check("post_reset_trig", ringing[0], 1);

    // randomized traffic checked by the scoreboard
    alarm_arm = 2'b11;
    set_alarm(0, 16'h0700, 1'b0); set_alarm(1, 16'h0701, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0)
        set_clock($urandom_range(0, 1) ? 16'h0701 : 16'h0700, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 299) == 0)
        set_alarm($urandom_range(0, NA - 1), $urandom_range(0, 1) ? 16'h0701 : 16'h0700,
                  1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) alarm_arm[$urandom_range(0, NA - 1)] ^= 1'b1;
      snooze  = ($urandom_range(0, 7) == 0);
      dismiss = ($urandom_range(0, 149) == 0);
      en      = ($urandom_range(0, 499) != 0);
      tick();
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
